// File: rtl/ysyx_22040125_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage indices and control-bundle bit positions are common to all pipeline blocks.
package ysyx_22040125_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      StRun = 1'b0,
      StLu  = 1'b1
   } hz_state_e;

   localparam int unsigned StageIf = 0;
   localparam int unsigned StageId = 1;
   localparam int unsigned StageEx = 2;

   localparam int unsigned CtrlDataWen = 0;
   localparam int unsigned CtrlDataRen = 1;
   localparam int unsigned CtrlRegWen  = 2;

   // Wide enough for the largest legal LU_CYCLES (15).
   localparam int unsigned LuCntW = 4;

endpackage

// File: rtl/ysyx_22040125_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module ysyx_22040125_sat_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != {Width{1'b1}})) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_22040125_hazard_ctrl.sv
// Central stall/flush controller: load-use stalls, memory freeze, redirect flushes
// (latched while frozen) and EX control gating, plus a stall-cycle counter.
module ysyx_22040125_hazard_ctrl
   import ysyx_22040125_hazard_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = 5,
   parameter int unsigned CTRL_W      = 3,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LU_CYCLES   = 1,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_AW-1:0]     id_rs1,
   input  logic [REG_AW-1:0]     id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_AW-1:0]     ex_rd,
   input  logic                  ex_is_load,
   input  logic                  mem_busy,
   input  logic                  flush_req,
   input  logic [CTRL_W-1:0]     ctrl_in,
   output logic [CTRL_W-1:0]     ctrl_out,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] stage_flush,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic                  flush_pending
);

   hz_state_e         state_d, state_q;
   logic [LuCntW-1:0] lu_cnt_d, lu_cnt_q;
   logic              flush_pending_d, flush_pending_q;

   logic                  haz;
   logic                  eff_flush;
   logic [NUM_STAGES-1:0] stage_en_c;
   logic [NUM_STAGES-1:0] stage_flush_c;
   logic [CTRL_W-1:0]     ctrl_c;

   assign haz = ex_is_load && (ex_rd != '0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

   assign eff_flush = flush_req || flush_pending_q;

   always_comb begin
      state_d         = state_q;
      lu_cnt_d        = lu_cnt_q;
      flush_pending_d = flush_pending_q;
      stage_en_c      = '1;
      stage_flush_c   = '0;
      ctrl_c          = ctrl_in;

      if (mem_busy) begin
         // Full freeze; a redirect arriving now is remembered for the release cycle.
         stage_en_c = '0;
         if (flush_req) begin
            flush_pending_d = 1'b1;
         end
      end else if (eff_flush) begin
         for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (i < FLUSH_DEPTH) begin
               stage_flush_c[i] = 1'b1;
            end
         end
         ctrl_c          = '0;
         flush_pending_d = 1'b0;
         state_d         = StRun;
         lu_cnt_d        = '0;
      end else if ((state_q == StLu) || haz) begin
         stage_en_c[StageIf] = 1'b0;
         stage_en_c[StageId] = 1'b0;
         ctrl_c              = '0;
         if (state_q == StLu) begin
            lu_cnt_d = lu_cnt_q - LuCntW'(1);
            if (lu_cnt_q == LuCntW'(1)) begin
               state_d = StRun;
            end
         end else if (LU_CYCLES > 1) begin
            state_d  = StLu;
            lu_cnt_d = LuCntW'(LU_CYCLES - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StRun;
         lu_cnt_q        <= '0;
         flush_pending_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         lu_cnt_q        <= lu_cnt_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   // Outputs are forced quiet while reset is asserted, independent of the clock.
   assign stage_en      = rst_n ? stage_en_c    : '0;
   assign stage_flush   = rst_n ? stage_flush_c : '0;
   assign ctrl_out      = rst_n ? ctrl_c        : '0;
   assign flush_pending = flush_pending_q;

   ysyx_22040125_sat_counter #(
      .Width(CNT_W)
   ) u_stall_cnt (
      .clk_i (clk),
      .rst_ni(rst_n),
      .en_i  (!stage_en_c[StageIf]),
      .cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_ysyx_22040125_hazard_ctrl.sv
// Directed bench: three controller instances (LU_CYCLES=2, LU_CYCLES=3, CNT_W=4) share stimulus.
module tb_ysyx_22040125_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_is_load, mem_busy, flush_req;
   logic [2:0] ctrl_in;

   logic [2:0]  ctrl_a, ctrl_b, ctrl_c;
   logic [4:0]  en_a, en_b, en_c, fl_a, fl_b, fl_c;
   logic [31:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;
   logic        fp_a, fp_b, fp_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_22040125_hazard_ctrl #(.LU_CYCLES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_busy(mem_busy),
      .flush_req(flush_req), .ctrl_in(ctrl_in), .ctrl_out(ctrl_a), .stage_en(en_a),
      .stage_flush(fl_a), .stall_cnt(cnt_a), .flush_pending(fp_a)
   );

   ysyx_22040125_hazard_ctrl #(.LU_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_busy(mem_busy),
      .flush_req(flush_req), .ctrl_in(ctrl_in), .ctrl_out(ctrl_b), .stage_en(en_b),
      .stage_flush(fl_b), .stall_cnt(cnt_b), .flush_pending(fp_b)
   );

   ysyx_22040125_hazard_ctrl #(.LU_CYCLES(1), .CNT_W(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_busy(mem_busy),
      .flush_req(flush_req), .ctrl_in(ctrl_in), .ctrl_out(ctrl_c), .stage_en(en_c),
      .stage_flush(fl_c), .stall_cnt(cnt_c), .flush_pending(fp_c)
   );

   task automatic clr_in();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
      mem_busy = 1'b0; flush_req = 1'b0; ctrl_in = 3'b111;
   endtask

   task automatic set_haz();
      ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         clr_in();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr_in();
      #2;
      total++; if (en_a !== 5'b00000) begin bad++; $display("FAIL rst_en got=%b exp=00000", en_a); end
      total++; if (fl_a !== 5'b00000) begin bad++; $display("FAIL rst_flush got=%b exp=00000", fl_a); end
      total++; if (ctrl_a !== 3'b000) begin bad++; $display("FAIL rst_ctrl got=%b exp=000", ctrl_a); end
      total++; if (cnt_a !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt_a); end
      total++; if (fp_a !== 1'b0) begin bad++; $display("FAIL rst_fp got=%b exp=0", fp_a); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL post_rst_en got=%b exp=11111", en_a); end
      total++; if (ctrl_a !== 3'b111) begin bad++; $display("FAIL post_rst_ctrl got=%b exp=111", ctrl_a); end
   endtask

   task automatic test_load_use();
      @(negedge clk); set_haz(); #1;
      total++; if (en_a !== 5'b11100) begin bad++; $display("FAIL lu_c1_en got=%b exp=11100", en_a); end
      total++; if (ctrl_a !== 3'b000) begin bad++; $display("FAIL lu_c1_ctrl got=%b exp=000", ctrl_a); end
      total++; if (fl_a !== 5'b00000) begin bad++; $display("FAIL lu_c1_flush got=%b exp=00000", fl_a); end
      @(negedge clk); #1;
      total++; if (en_a !== 5'b11100) begin bad++; $display("FAIL lu_c2_en got=%b exp=11100", en_a); end
      total++; if (ctrl_a !== 3'b000) begin bad++; $display("FAIL lu_c2_ctrl got=%b exp=000", ctrl_a); end
      @(negedge clk); clr_in(); #1;
      total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL lu_c3_en got=%b exp=11111", en_a); end
      total++; if (ctrl_a !== 3'b111) begin bad++; $display("FAIL lu_c3_ctrl got=%b exp=111", ctrl_a); end
      total++; if (cnt_a !== 32'd2) begin bad++; $display("FAIL lu_cnt got=%0d exp=2", cnt_a); end
      total++; if (en_b !== 5'b11100) begin bad++; $display("FAIL lu3_c3_en got=%b exp=11100", en_b); end
      @(negedge clk); #1;
      total++; if (en_b !== 5'b11111) begin bad++; $display("FAIL lu3_c4_en got=%b exp=11111", en_b); end
   endtask

   task automatic test_no_stall();
      @(negedge clk); ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1; #1;
      total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL rd0_en got=%b exp=11111", en_a); end
      total++; if (ctrl_a !== 3'b111) begin bad++; $display("FAIL rd0_ctrl got=%b exp=111", ctrl_a); end
      @(negedge clk); ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b0; #1;
      total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL rs2_unused_en got=%b exp=11111", en_a); end
      total++; if (ctrl_a !== 3'b111) begin bad++; $display("FAIL rs2_unused_ctrl got=%b exp=111", ctrl_a); end
      @(negedge clk); ex_is_load = 1'b0; id_rs2_used = 1'b1; #1;
      total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL noload_en got=%b exp=11111", en_a); end
      @(negedge clk); ex_is_load = 1'b1; #1;
      total++; if (en_a !== 5'b11100) begin bad++; $display("FAIL rs2_haz_en got=%b exp=11100", en_a); end
      @(negedge clk); clr_in(); #1;
      total++; if (en_a !== 5'b11100) begin bad++; $display("FAIL rs2_haz_c2_en got=%b exp=11100", en_a); end
      idle(3);
   endtask

   task automatic test_busy_flush();
      @(negedge clk); mem_busy = 1'b1; #1;
      total++; if (en_a !== 5'b00000) begin bad++; $display("FAIL busy_en got=%b exp=00000", en_a); end
      total++; if (fl_a !== 5'b00000) begin bad++; $display("FAIL busy_flush got=%b exp=00000", fl_a); end
      total++; if (ctrl_a !== 3'b111) begin bad++; $display("FAIL busy_ctrl got=%b exp=111", ctrl_a); end
      @(negedge clk); flush_req = 1'b1; #1;
      total++; if (fl_a !== 5'b00000) begin bad++; $display("FAIL busy_fr_flush got=%b exp=00000", fl_a); end
      @(negedge clk); flush_req = 1'b0; #1;
      total++; if (fp_a !== 1'b1) begin bad++; $display("FAIL fp_set got=%b exp=1", fp_a); end
      total++; if (en_a !== 5'b00000) begin bad++; $display("FAIL busy_c3_en got=%b exp=00000", en_a); end
      @(negedge clk); mem_busy = 1'b0; #1;
      total++; if (fl_a !== 5'b00011) begin bad++; $display("FAIL rel_flush got=%b exp=00011", fl_a); end
      total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL rel_en got=%b exp=11111", en_a); end
      total++; if (ctrl_a !== 3'b000) begin bad++; $display("FAIL rel_ctrl got=%b exp=000", ctrl_a); end
      @(negedge clk); #1;
      total++; if (fp_a !== 1'b0) begin bad++; $display("FAIL fp_clr got=%b exp=0", fp_a); end
      total++; if (fl_a !== 5'b00000) begin bad++; $display("FAIL after_rel_flush got=%b exp=00000", fl_a); end
      total++; if (ctrl_a !== 3'b111) begin bad++; $display("FAIL after_rel_ctrl got=%b exp=111", ctrl_a); end
      // Repeated flush_req while busy, and again on the release cycle: one flush only.
      @(negedge clk); mem_busy = 1'b1; flush_req = 1'b1;
      @(negedge clk); #1;
      total++; if (fp_a !== 1'b1) begin bad++; $display("FAIL fp_b2b got=%b exp=1", fp_a); end
      @(negedge clk); mem_busy = 1'b0; #1;
      total++; if (fl_a !== 5'b00011) begin bad++; $display("FAIL b2b_flush got=%b exp=00011", fl_a); end
      @(negedge clk); flush_req = 1'b0; #1;
      total++; if (fl_a !== 5'b00000) begin bad++; $display("FAIL b2b_single got=%b exp=00000", fl_a); end
      total++; if (fp_a !== 1'b0) begin bad++; $display("FAIL b2b_fp got=%b exp=0", fp_a); end
   endtask

   task automatic test_flush_in_lu();
      @(negedge clk); set_haz(); #1;
      total++; if (en_b !== 5'b11100) begin bad++; $display("FAIL fl_lu_c1_en got=%b exp=11100", en_b); end
      @(negedge clk); clr_in(); flush_req = 1'b1; #1;
      total++; if (en_b !== 5'b11111) begin bad++; $display("FAIL fl_lu_en got=%b exp=11111", en_b); end
      total++; if (fl_b !== 5'b00011) begin bad++; $display("FAIL fl_lu_flush got=%b exp=00011", fl_b); end
      total++; if (ctrl_b !== 3'b000) begin bad++; $display("FAIL fl_lu_ctrl got=%b exp=000", ctrl_b); end
      @(negedge clk); flush_req = 1'b0; #1;
      total++; if (en_b !== 5'b11111) begin bad++; $display("FAIL fl_lu_after_en got=%b exp=11111", en_b); end
      total++; if (fl_b !== 5'b00000) begin bad++; $display("FAIL fl_lu_after_fl got=%b exp=00000", fl_b); end
   endtask

   task automatic test_lu_busy();
      @(negedge clk); set_haz(); #1;
      total++; if (en_b !== 5'b11100) begin bad++; $display("FAIL lub_c1_en got=%b exp=11100", en_b); end
      @(negedge clk); clr_in(); mem_busy = 1'b1; #1;
      total++; if (en_b !== 5'b00000) begin bad++; $display("FAIL lub_c2_en got=%b exp=00000", en_b); end
      @(negedge clk); mem_busy = 1'b0; #1;
      total++; if (en_b !== 5'b11100) begin bad++; $display("FAIL lub_c3_en got=%b exp=11100", en_b); end
      total++; if (en_a !== 5'b11100) begin bad++; $display("FAIL lub2_c3_en got=%b exp=11100", en_a); end
      @(negedge clk); #1;
      total++; if (en_b !== 5'b11100) begin bad++; $display("FAIL lub_c4_en got=%b exp=11100", en_b); end
      total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL lub2_c4_en got=%b exp=11111", en_a); end
      @(negedge clk); #1;
      total++; if (en_b !== 5'b11111) begin bad++; $display("FAIL lub_c5_en got=%b exp=11111", en_b); end
   endtask

   task automatic test_async_reset();
      @(negedge clk); set_haz(); #1;
      @(negedge clk); clr_in(); #1;
      total++; if (en_b !== 5'b11100) begin bad++; $display("FAIL ar_pre_en got=%b exp=11100", en_b); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (en_b !== 5'b00000) begin bad++; $display("FAIL ar_en got=%b exp=00000", en_b); end
      total++; if (fl_b !== 5'b00000) begin bad++; $display("FAIL ar_flush got=%b exp=00000", fl_b); end
      total++; if (ctrl_b !== 3'b000) begin bad++; $display("FAIL ar_ctrl got=%b exp=000", ctrl_b); end
      total++; if (cnt_b !== 32'd0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", cnt_b); end
      total++; if (fp_b !== 1'b0) begin bad++; $display("FAIL ar_fp got=%b exp=0", fp_b); end
      @(negedge clk); rst_n = 1'b1; #1;
      total++; if (en_b !== 5'b11111) begin bad++; $display("FAIL ar_rel_en got=%b exp=11111", en_b); end
      total++; if (ctrl_b !== 3'b111) begin bad++; $display("FAIL ar_rel_ctrl got=%b exp=111", ctrl_b); end
      total++; if (cnt_b !== 32'd0) begin bad++; $display("FAIL ar_rel_cnt got=%0d exp=0", cnt_b); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk); mem_busy = 1'b1; #1;
         if (i == 14) begin
            total++; if (cnt_c !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d exp=14", cnt_c); end
         end
         if (i == 15) begin
            total++; if (cnt_c !== 4'hF) begin bad++; $display("FAIL sat_15 got=%0d exp=15", cnt_c); end
         end
         if (i == 20) begin
            total++; if (cnt_c !== 4'hF) begin bad++; $display("FAIL sat_hold got=%0d exp=15", cnt_c); end
            total++; if (cnt_a !== 32'd20) begin bad++; $display("FAIL cnt32_20 got=%0d exp=20", cnt_a); end
         end
      end
      @(negedge clk); mem_busy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_busy_flush();
      test_flush_in_lu();
      test_lu_busy();
      test_async_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
